// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with saturating direction counters, execute-stage
// mispredict check and saturating performance counters.
module branch_predictor #(
   parameter int XLEN      = 32,
   parameter int ENTRIES   = 16,
   parameter int TAG_BITS  = 8,
   parameter int CNT_BITS  = 2,
   parameter int PERF_BITS = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 clear_i,
   input  logic [XLEN-1:0]      if_pc_i,
   output logic                 pred_taken_o,
   output logic [XLEN-1:0]      pred_target_o,
   input  logic                 ex_valid_i,
   input  logic [XLEN-1:0]      ex_pc_i,
   input  logic                 ex_is_branch_i,
   input  logic                 ex_is_jump_i,
   input  logic                 ex_taken_i,
   input  logic [XLEN-1:0]      ex_target_i,
   input  logic                 ex_pred_taken_i,
   input  logic [XLEN-1:0]      ex_pred_target_i,
   output logic                 mispredict_o,
   output logic [XLEN-1:0]      redirect_pc_o,
   output logic [PERF_BITS-1:0] perf_ctrl_o,
   output logic [PERF_BITS-1:0] perf_miss_o
);
   localparam int IDX = $clog2(ENTRIES);
   localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
   localparam logic [CNT_BITS-1:0] CNT_WT  = CNT_BITS'(1 << (CNT_BITS - 1));
   localparam logic [CNT_BITS-1:0] CNT_WNT = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);

   logic [ENTRIES-1:0]  r_valid;
   logic [ENTRIES-1:0]  r_jump;
   logic [TAG_BITS-1:0] r_tag    [ENTRIES];
   logic [XLEN-1:0]     r_target [ENTRIES];
   logic [CNT_BITS-1:0] r_cnt    [ENTRIES];
   logic [PERF_BITS-1:0] r_perf_ctrl, r_perf_miss;

   logic [IDX-1:0]      w_if_idx, w_ex_idx;
   logic [TAG_BITS-1:0] w_if_tag, w_ex_tag;
   logic                w_if_hit, w_ex_hit, w_ex_ctrl;
   logic                w_alloc, w_train, w_kill;
   logic [CNT_BITS-1:0] w_cnt_nxt;
   logic [ENTRIES-1:0]  w_ex_onehot;

   assign w_if_idx = if_pc_i[IDX+1:2];
   assign w_if_tag = if_pc_i[IDX+2 +: TAG_BITS];
   assign w_if_hit = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);

   assign pred_taken_o  = w_if_hit && (r_jump[w_if_idx] || r_cnt[w_if_idx][CNT_BITS-1]);
   assign pred_target_o = pred_taken_o ? r_target[w_if_idx] : if_pc_i + XLEN'(4);

   assign w_ex_idx    = ex_pc_i[IDX+1:2];
   assign w_ex_tag    = ex_pc_i[IDX+2 +: TAG_BITS];
   assign w_ex_hit    = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
   assign w_ex_ctrl   = ex_is_branch_i || ex_is_jump_i;
   assign w_ex_onehot = ENTRIES'(1) << w_ex_idx;

   assign mispredict_o  = ex_valid_i && (w_ex_ctrl
                          ? (ex_pred_taken_i != ex_taken_i) || (ex_taken_i && ex_pred_target_i != ex_target_i)
                          : ex_pred_taken_i);
   assign redirect_pc_o = ex_taken_i ? ex_target_i : ex_pc_i + XLEN'(4);

   assign w_train   = ex_valid_i && w_ex_ctrl && w_ex_hit;
   assign w_alloc   = ex_valid_i && w_ex_ctrl && !w_ex_hit && ex_taken_i;
   // a non-control instruction hitting means the entry aliases a different PC
   assign w_kill    = ex_valid_i && !w_ex_ctrl && w_ex_hit;
   assign w_cnt_nxt = ex_taken_i
                      ? ((r_cnt[w_ex_idx] == CNT_MAX) ? CNT_MAX : r_cnt[w_ex_idx] + CNT_BITS'(1))
                      : ((r_cnt[w_ex_idx] == '0) ? '0 : r_cnt[w_ex_idx] - CNT_BITS'(1));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_valid <= '0;
         r_jump  <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            r_tag[i]    <= '0;
            r_target[i] <= '0;
            r_cnt[i]    <= CNT_WNT;
         end
      end else begin
         if (w_alloc || w_train) begin
            r_cnt[w_ex_idx] <= w_alloc ? CNT_WT : w_cnt_nxt;
            if (ex_taken_i) begin
               r_target[w_ex_idx] <= ex_target_i;
               r_jump[w_ex_idx]   <= ex_is_jump_i;
            end
         end
         if (w_alloc) r_tag[w_ex_idx] <= w_ex_tag;
         r_valid <= clear_i ? '0
                  : w_alloc ? (r_valid | w_ex_onehot)
                  : w_kill  ? (r_valid & ~w_ex_onehot)
                  : r_valid;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_perf_ctrl <= '0;
         r_perf_miss <= '0;
      end else begin
         if (ex_valid_i && w_ex_ctrl && ~&r_perf_ctrl) r_perf_ctrl <= r_perf_ctrl + PERF_BITS'(1);
         if (mispredict_o && ~&r_perf_miss) r_perf_miss <= r_perf_miss + PERF_BITS'(1);
      end
   end

   assign perf_ctrl_o = r_perf_ctrl;
   assign perf_miss_o = r_perf_miss;
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed scenarios plus a random stream against a behavioural BTB model,
// expectations queued at stimulus time and popped once the outputs have settled.
module tb_branch_predictor;
   logic        clk_i = 1'b0, rst_i, clear_i;
   logic [31:0] if_pc_i, pred_target_o;
   logic        pred_taken_o;
   logic        ex_valid_i, ex_is_branch_i, ex_is_jump_i, ex_taken_i, ex_pred_taken_i;
   logic [31:0] ex_pc_i, ex_target_i, ex_pred_target_i;
   logic        mispredict_o;
   logic [31:0] redirect_pc_o, perf_ctrl_o, perf_miss_o;

   always #5 clk_i = ~clk_i;

   branch_predictor dut (
      .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .if_pc_i(if_pc_i),
      .pred_taken_o(pred_taken_o), .pred_target_o(pred_target_o),
      .ex_valid_i(ex_valid_i), .ex_pc_i(ex_pc_i), .ex_is_branch_i(ex_is_branch_i),
      .ex_is_jump_i(ex_is_jump_i), .ex_taken_i(ex_taken_i), .ex_target_i(ex_target_i),
      .ex_pred_taken_i(ex_pred_taken_i), .ex_pred_target_i(ex_pred_target_i),
      .mispredict_o(mispredict_o), .redirect_pc_o(redirect_pc_o),
      .perf_ctrl_o(perf_ctrl_o), .perf_miss_o(perf_miss_o)
   );

   localparam int PT = 0, PG = 1, MP = 2, RD = 3, PC = 4, PM = 5;
   typedef struct { string name; int sel; logic [31:0] v; } exp_t;
   exp_t sb[$];
   exp_t e;
   int n_chk = 0, n_fail = 0;

   bit          m_valid [16];
   bit          m_jump  [16];
   logic [7:0]  m_tag   [16];
   logic [31:0] m_tgt   [16];
   int          m_cnt   [16];
   int          m_ctrl, m_miss;

   function automatic logic [31:0] obs(int s);
      case (s)
         PT: return {31'b0, pred_taken_o};
         PG: return pred_target_o;
         MP: return {31'b0, mispredict_o};
         RD: return redirect_pc_o;
         PC: return perf_ctrl_o;
         default: return perf_miss_o;
      endcase
   endfunction

   task automatic push(input string n, input int s, input logic [31:0] v);
      sb.push_back('{n, s, v});
   endtask

   task automatic set_ex(input logic v, input logic [31:0] pc, input logic br, input logic jmp,
                         input logic tk, input logic [31:0] tg, input logic ptk, input logic [31:0] ptg);
      ex_valid_i = v; ex_pc_i = pc; ex_is_branch_i = br; ex_is_jump_i = jmp;
      ex_taken_i = tk; ex_target_i = tg; ex_pred_taken_i = ptk; ex_pred_target_i = ptg;
   endtask

   task automatic test_reset();
      rst_i = 1'b1; clear_i = 1'b0; if_pc_i = 32'h100;
      set_ex(0, 0, 0, 0, 0, 0, 0, 0);
      push("rst_pred_taken", PT, 0); push("rst_pred_target", PG, 32'h104);
      push("rst_perf_ctrl", PC, 0); push("rst_perf_miss", PM, 0);
      #2; while (sb.size() > 0) begin e = sb.pop_front(); n_chk++; if (obs(e.sel) !== e.v) begin n_fail++; $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, obs(e.sel), e.v); end end
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
      push("post_rst_pred_taken", PT, 0); push("post_rst_pred_target", PG, 32'h104);
      #1; while (sb.size() > 0) begin e = sb.pop_front(); n_chk++; if (obs(e.sel) !== e.v) begin n_fail++; $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, obs(e.sel), e.v); end end
   endtask

   task automatic test_taken_branch();
      @(negedge clk_i);
      if_pc_i = 32'h100; set_ex(1, 32'h100, 1, 0, 1, 32'h80, 0, 32'h104);
      push("tb_no_bypass_taken", PT, 0); push("tb_no_bypass_target", PG, 32'h104);
      push("tb_mispredict", MP, 1); push("tb_redirect", RD, 32'h80);
      #1; while (sb.size() > 0) begin e = sb.pop_front(); n_chk++; if (obs(e.sel) !== e.v) begin n_fail++; $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, obs(e.sel), e.v); end end
      @(negedge clk_i);
      set_ex(0, 0, 0, 0, 0, 0, 0, 0);
      push("tb_pred_taken", PT, 1); push("tb_pred_target", PG, 32'h80);
      push("tb_idle_mispredict", MP, 0); push("tb_perf_ctrl", PC, 1); push("tb_perf_miss", PM, 1);
      #1; while (sb.size() > 0) begin e = sb.pop_front(); n_chk++; if (obs(e.sel) !== e.v) begin n_fail++; $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, obs(e.sel), e.v); end end
   endtask

   task automatic test_not_taken();
      logic        ptk [3] = '{1, 0, 0};
      logic [31:0] ptg [3] = '{32'h80, 32'h104, 32'h104};
      for (int k = 0; k < 3; k++) begin
         @(negedge clk_i);
         if_pc_i = 32'h100; set_ex(1, 32'h100, 1, 0, 0, 32'h80, ptk[k], ptg[k]);
         push($sformatf("nt%0d_pred_taken", k), PT, {31'b0, ptk[k]});
         push($sformatf("nt%0d_pred_target", k), PG, ptg[k]);
         push($sformatf("nt%0d_mispredict", k), MP, {31'b0, ptk[k]});
         push($sformatf("nt%0d_redirect", k), RD, 32'h104);
         #1; while (sb.size() > 0) begin e = sb.pop_front(); n_chk++; if (obs(e.sel) !== e.v) begin n_fail++; $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, obs(e.sel), e.v); end end
      end
      @(negedge clk_i);
      set_ex(1, 32'h100, 1, 0, 1, 32'h80, 0, 32'h104);
      push("nt_sat_pred_taken", PT, 0); push("nt_perf_ctrl", PC, 4); push("nt_perf_miss", PM, 2);
      push("nt_retake_mispredict", MP, 1);
      #1; while (sb.size() > 0) begin e = sb.pop_front(); n_chk++; if (obs(e.sel) !== e.v) begin n_fail++; $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, obs(e.sel), e.v); end end
      @(negedge clk_i);
      set_ex(0, 0, 0, 0, 0, 0, 0, 0);
      push("nt_cnt1_pred_taken", PT, 0); push("nt_cnt1_pred_target", PG, 32'h104);
      push("nt_perf_ctrl2", PC, 5); push("nt_perf_miss2", PM, 3);
      #1; while (sb.size() > 0) begin e = sb.pop_front(); n_chk++; if (obs(e.sel) !== e.v) begin n_fail++; $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, obs(e.sel), e.v); end end
   endtask

   task automatic test_alias();
      @(negedge clk_i);
      if_pc_i = 32'h200; set_ex(1, 32'h200, 0, 1, 1, 32'h400, 0, 32'h204);
      push("al_jal_mispredict", MP, 1); push("al_jal_redirect", RD, 32'h400); push("al_jal_pred_taken", PT, 0);
      #1; while (sb.size() > 0) begin e = sb.pop_front(); n_chk++; if (obs(e.sel) !== e.v) begin n_fail++; $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, obs(e.sel), e.v); end end
      @(negedge clk_i);
      set_ex(1, 32'h240, 0, 0, 0, 0, 0, 0);
      push("al_jal_hit_taken", PT, 1); push("al_jal_hit_target", PG, 32'h400);
      push("al_add_mispredict", MP, 0); push("al_add_redirect", RD, 32'h244);
      #1; while (sb.size() > 0) begin e = sb.pop_front(); n_chk++; if (obs(e.sel) !== e.v) begin n_fail++; $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, obs(e.sel), e.v); end end
      @(negedge clk_i);
      if_pc_i = 32'h240; set_ex(0, 0, 0, 0, 0, 0, 0, 0);
      push("al_alias_taken", PT, 0); push("al_alias_target", PG, 32'h244);
      #1; while (sb.size() > 0) begin e = sb.pop_front(); n_chk++; if (obs(e.sel) !== e.v) begin n_fail++; $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, obs(e.sel), e.v); end end
      @(negedge clk_i);
      if_pc_i = 32'h200; set_ex(1, 32'h200, 0, 0, 0, 0, 1, 32'h400);
      push("al_still_hit", PT, 1); push("al_add_hit_mispredict", MP, 1); push("al_add_hit_redirect", RD, 32'h204);
      #1; while (sb.size() > 0) begin e = sb.pop_front(); n_chk++; if (obs(e.sel) !== e.v) begin n_fail++; $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, obs(e.sel), e.v); end end
      @(negedge clk_i);
      set_ex(0, 0, 0, 0, 0, 0, 0, 0);
      push("al_invalidated_taken", PT, 0); push("al_invalidated_target", PG, 32'h204);
      push("al_perf_ctrl", PC, 6); push("al_perf_miss", PM, 5);
      #1; while (sb.size() > 0) begin e = sb.pop_front(); n_chk++; if (obs(e.sel) !== e.v) begin n_fail++; $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, obs(e.sel), e.v); end end
   endtask

   task automatic test_target();
      logic [31:0] act [3] = '{32'h500, 32'h600, 32'h600};
      logic        ptk [3] = '{0, 1, 1};
      logic [31:0] ptg [3] = '{32'h304, 32'h500, 32'h600};
      logic        mp  [3] = '{1, 1, 0};
      for (int k = 0; k < 3; k++) begin
         @(negedge clk_i);
         if_pc_i = 32'h300; set_ex(1, 32'h300, 0, 1, 1, act[k], ptk[k], ptg[k]);
         push($sformatf("tg%0d_pred_taken", k), PT, {31'b0, ptk[k]});
         push($sformatf("tg%0d_pred_target", k), PG, ptg[k]);
         push($sformatf("tg%0d_mispredict", k), MP, {31'b0, mp[k]});
         push($sformatf("tg%0d_redirect", k), RD, act[k]);
         #1; while (sb.size() > 0) begin e = sb.pop_front(); n_chk++; if (obs(e.sel) !== e.v) begin n_fail++; $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, obs(e.sel), e.v); end end
      end
      @(negedge clk_i);
      set_ex(0, 0, 0, 0, 0, 0, 0, 0);
      push("tg_final_target", PG, 32'h600); push("tg_perf_ctrl", PC, 9); push("tg_perf_miss", PM, 7);
      #1; while (sb.size() > 0) begin e = sb.pop_front(); n_chk++; if (obs(e.sel) !== e.v) begin n_fail++; $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, obs(e.sel), e.v); end end
   endtask

   task automatic test_clear();
      @(negedge clk_i);
      clear_i = 1'b1; if_pc_i = 32'h300; set_ex(1, 32'h404, 1, 0, 1, 32'h40, 0, 32'h408);
      push("cl_old_taken", PT, 1); push("cl_mispredict", MP, 1); push("cl_redirect", RD, 32'h40);
      #1; while (sb.size() > 0) begin e = sb.pop_front(); n_chk++; if (obs(e.sel) !== e.v) begin n_fail++; $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, obs(e.sel), e.v); end end
      @(negedge clk_i);
      clear_i = 1'b0; set_ex(0, 0, 0, 0, 0, 0, 0, 0);
      push("cl_miss_taken", PT, 0); push("cl_miss_target", PG, 32'h304);
      push("cl_perf_ctrl", PC, 10); push("cl_perf_miss", PM, 8);
      #1; while (sb.size() > 0) begin e = sb.pop_front(); n_chk++; if (obs(e.sel) !== e.v) begin n_fail++; $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, obs(e.sel), e.v); end end
      @(negedge clk_i);
      if_pc_i = 32'h404;
      push("cl_wins_taken", PT, 0); push("cl_wins_target", PG, 32'h408);
      #1; while (sb.size() > 0) begin e = sb.pop_front(); n_chk++; if (obs(e.sel) !== e.v) begin n_fail++; $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, obs(e.sel), e.v); end end
   endtask

   task automatic test_async_reset();
      @(negedge clk_i);
      if_pc_i = 32'h100; set_ex(1, 32'h100, 1, 0, 1, 32'h80, 0, 32'h104);
      @(negedge clk_i);
      set_ex(0, 0, 0, 0, 0, 0, 0, 0);
      push("ar_pre_taken", PT, 1); push("ar_pre_perf_ctrl", PC, 11); push("ar_pre_perf_miss", PM, 9);
      #1; while (sb.size() > 0) begin e = sb.pop_front(); n_chk++; if (obs(e.sel) !== e.v) begin n_fail++; $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, obs(e.sel), e.v); end end
      #1;
      rst_i = 1'b1; set_ex(1, 32'h500, 0, 0, 0, 0, 1, 0);
      push("ar_perf_ctrl", PC, 0); push("ar_perf_miss", PM, 0);
      push("ar_pred_taken", PT, 0); push("ar_pred_target", PG, 32'h104);
      push("ar_comb_mispredict", MP, 1); push("ar_comb_redirect", RD, 32'h504);
      #1; while (sb.size() > 0) begin e = sb.pop_front(); n_chk++; if (obs(e.sel) !== e.v) begin n_fail++; $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, obs(e.sel), e.v); end end
      @(negedge clk_i);
      rst_i = 1'b0; set_ex(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic model_pred(input logic [31:0] pc, output logic pt, output logic [31:0] tgt);
      int i;
      i = int'(pc[5:2]);
      pt  = m_valid[i] && m_tag[i] == pc[13:6] && (m_jump[i] || m_cnt[i] >= 2);
      tgt = pt ? m_tgt[i] : pc + 32'd4;
   endtask

   task automatic test_random();
      logic        pt, ctrl, hit, mp;
      logic [31:0] ptg;
      int          i, kind;
      @(negedge clk_i);
      rst_i = 1'b1; #1; rst_i = 1'b0;
      for (int k = 0; k < 16; k++) begin m_valid[k] = 0; m_jump[k] = 0; m_tag[k] = 0; m_tgt[k] = 0; m_cnt[k] = 1; end
      m_ctrl = 0; m_miss = 0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk_i);
         if_pc_i = 32'h1000 + 4 * $urandom_range(0, 3) + 64 * $urandom_range(0, 1);
         ex_pc_i = 32'h1000 + 4 * $urandom_range(0, 3) + 64 * $urandom_range(0, 1);
         kind = $urandom_range(0, 3);
         ex_valid_i = ($urandom_range(0, 3) != 0);
         ex_is_branch_i = (kind == 0 || kind == 3);
         ex_is_jump_i = (kind == 1 || kind == 3);
         ex_taken_i = ex_is_jump_i ? 1'b1 : 1'($urandom_range(0, 1));
         ex_target_i = 32'h2000 + 4 * $urandom_range(0, 3);
         model_pred(ex_pc_i, pt, ptg);
         ex_pred_taken_i = ($urandom_range(0, 3) != 0) ? pt : 1'($urandom_range(0, 1));
         ex_pred_target_i = ($urandom_range(0, 3) != 0) ? ptg : 32'h2000 + 4 * $urandom_range(0, 3);
         clear_i = ($urandom_range(0, 15) == 0);
         ctrl = ex_is_branch_i || ex_is_jump_i;
         mp = ex_valid_i && (ctrl ? (ex_pred_taken_i != ex_taken_i || (ex_taken_i && ex_pred_target_i != ex_target_i)) : ex_pred_taken_i);
         model_pred(if_pc_i, pt, ptg);
         push("rnd_pred_taken", PT, {31'b0, pt}); push("rnd_pred_target", PG, ptg);
         push("rnd_mispredict", MP, {31'b0, mp});
         push("rnd_redirect", RD, ex_taken_i ? ex_target_i : ex_pc_i + 32'd4);
         push("rnd_perf_ctrl", PC, m_ctrl); push("rnd_perf_miss", PM, m_miss);
         #1; while (sb.size() > 0) begin e = sb.pop_front(); n_chk++; if (obs(e.sel) !== e.v) begin n_fail++; $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", e.name, c, obs(e.sel), e.v); end end
         i = int'(ex_pc_i[5:2]);
         hit = m_valid[i] && m_tag[i] == ex_pc_i[13:6];
         if (ex_valid_i && ctrl && hit) begin
            m_cnt[i] = ex_taken_i ? (m_cnt[i] < 3 ? m_cnt[i] + 1 : 3) : (m_cnt[i] > 0 ? m_cnt[i] - 1 : 0);
            if (ex_taken_i) begin m_tgt[i] = ex_target_i; m_jump[i] = ex_is_jump_i; end
         end else if (ex_valid_i && ctrl && ex_taken_i) begin
            m_valid[i] = 1; m_tag[i] = ex_pc_i[13:6]; m_tgt[i] = ex_target_i; m_jump[i] = ex_is_jump_i; m_cnt[i] = 2;
         end else if (ex_valid_i && !ctrl && hit) m_valid[i] = 0;
         if (clear_i) for (int k = 0; k < 16; k++) m_valid[k] = 0;
         if (ex_valid_i && ctrl) m_ctrl++;
         if (mp) m_miss++;
      end
      @(negedge clk_i);
      clear_i = 1'b0; set_ex(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      test_reset();
      test_taken_branch();
      test_not_taken();
      test_alias();
      test_target();
      test_clear();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
Parametrised successor to the single-cycle branch resolver. It combines a direct-mapped branch target buffer, per-entry saturating direction counters and a misprediction checker. The fetch stage uses the combinational lookup port to get a predicted next PC. The execute stage feeds resolved outcomes back, and the block issues mispredict/redirect signals, updates its tables and keeps performance counters.

Parameters:
XLEN, 32, address/data width
ENTRIES, 16, BTB entries; power of two, >= 2
TAG_BITS, 8, stored tag width; log2(ENTRIES)+2+TAG_BITS <= XLEN
CNT_BITS, 2, direction counter width, >= 1
PERF_BITS, 32, width of each performance counter

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous active-high reset
clear_i  input  1  synchronous clear of all BTB valid bits (fence.i)
if_pc_i  input  XLEN  fetch PC to look up
pred_taken_o  output  1  predicted taken for if_pc_i
pred_target_o  output  XLEN  predicted next PC
ex_valid_i  input  1  execute-stage instruction valid
ex_pc_i  input  XLEN  PC of resolving instruction
ex_is_branch_i  input  1  conditional branch
ex_is_jump_i  input  1  JAL/JALR
ex_taken_i  input  1  resolved taken
ex_target_i  input  XLEN  resolved target
ex_pred_taken_i  input  1  prediction carried down the pipe
ex_pred_target_i  input  XLEN  predicted target carried down the pipe
mispredict_o  output  1  flush request
redirect_pc_o  output  XLEN  correct next PC when mispredict_o
perf_ctrl_o  output  PERF_BITS  resolved control-transfer count
perf_miss_o  output  PERF_BITS  mispredict count

Behaviour:
- Index is pc[IDX+1:2], with IDX = log2(ENTRIES). Tag is the next TAG_BITS bits above the index.
- Each entry holds: valid, tag, is_jump, target, counter.
- Lookup (combinational, zero latency):
  - Hit = valid and tag equal.
  - On a hit: pred_taken_o = is_jump or counter MSB. pred_target_o = stored target if taken, else if_pc_i+4.
  - On a miss: pred_taken_o = 0, pred_target_o = if_pc_i+4 (XLEN wrap).
- Check (combinational on ex_* inputs), gated by ex_valid_i:
  - Control instruction (is_branch or is_jump): mispredict_o = (ex_pred_taken_i != ex_taken_i) or (ex_taken_i and ex_pred_target_i != ex_target_i).
  - Non-control instruction: mispredict_o = ex_pred_taken_i.
  - redirect_pc_o = ex_taken_i ? ex_target_i : ex_pc_i+4. It is driven regardless of mispredict_o.
- Update (registered, at the rising edge when ex_valid_i):
  - Control instruction, hit: counter +1 if taken, -1 if not taken, saturating at 0 and 2^CNT_BITS-1. If taken, target and is_jump are overwritten.
  - Control instruction, miss, taken: allocate (replace). valid=1, tag, target, is_jump; counter = 2^(CNT_BITS-1) (weakly taken).
  - Control instruction, miss, not taken: no write.
  - Non-control instruction with hit: entry invalidated (aliasing).
- Update is not bypassed to lookup. A lookup in the same cycle as an update sees the old contents; the new contents are visible the next cycle.
- clear_i clears all valid bits at the edge. Counters and targets are untouched. clear_i wins over a simultaneous update to any entry.
- Performance counters:
  - perf_ctrl_o increments per valid control instruction.
  - perf_miss_o increments per mispredict_o cycle.
  - Both saturate at all-ones. Neither is cleared by clear_i.
- Reset (asynchronous, any time including mid-update):
  - All valid bits 0, counters 2^(CNT_BITS-1)-1 (weakly not taken), targets 0, perf counters 0.
  - Hence pred_taken_o=0 and pred_target_o=if_pc_i+4 during and after reset.
  - mispredict_o and redirect_pc_o remain combinational on their inputs.
- ex_is_branch_i and ex_is_jump_i both high is illegal. It is treated as a jump.

Test Plan:
- Reset, then lookup if_pc_i=0x100 -> pred_taken_o=0, pred_target_o=0x104. Both perf counters 0.
- Taken branch at 0x100, target 0x80, not predicted -> mispredict_o=1, redirect 0x80. Next-cycle lookup of 0x100 predicts taken to 0x80 (counter 2). perf_miss_o=1.
- Same branch resolved not taken three times -> counter 2→1→0→0 (saturates). Prediction becomes not taken after the first. Redirect 0x104 on each mispredict.
- JAL at 0x200 to 0x400, then an ADD at the aliasing PC 0x200+4*ENTRIES with a different tag -> lookup misses. ADD at exactly 0x200 with ex_pred_taken_i=1 -> mispredict, redirect 0x204, entry invalidated.
- Hit with correct direction but wrong target (JALR 0x300 predicted to 0x500, actual 0x600) -> mispredict_o=1, redirect 0x600, target updated.
- clear_i together with an update, then asserting rst_i mid-stream -> no hits after the clear. Asynchronous reset zeroes the perf counters without a clock edge.
